// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake between uart_rx_cfg and the register/FIFO layer:
// holding-register contents, per-frame flags and the sticky overrun.
`timescale 1ns/1ps
interface uart_rx_cfg_if;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       parity_err;
   logic       frame_err;
   logic       break_det;
   logic       overrun;
   logic       ovr_clr;

   modport master (
      output rx_valid, rx_data, parity_err, frame_err, break_det, overrun,
      input  rx_ready, ovr_clr
   );

   modport slave (
      input  rx_valid, rx_data, parity_err, frame_err, break_det, overrun,
      output rx_ready, ovr_clr
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: programmable divisor, 5-8 data bits, optional
// parity, 1/2 stop bits, 3-sample mid-bit vote, single-entry holding register.
`timescale 1ns/1ps
module uart_rx_cfg #(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             uart_en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [1:0]       data_bits,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic             RX,
   uart_rx_cfg_if.master    rx
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s, rx_s_prev;
   logic [2:0]             state;
   logic [DIV_W-1:0]       cnt, half;
   logic [1:0]             smp;
   logic                   at_s0, at_s1, at_vote, at_end, vote;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic [1:0]             cfg_bits;
   logic                   cfg_pen, cfg_podd, cfg_stop2;
   logic                   stop_idx, perr, ferr, seen_one;
   logic                   dlv, dlv_perr, dlv_ferr, dlv_brk;
   logic                   ovr_set;

   // NOTE: the synchroniser resets to the idle line level so reset release never looks like a start edge.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync      <= '1;
         rx_s_prev <= 1'b1;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], RX};
         rx_s_prev <= rx_s;
      end
   end

   assign rx_s    = sync[SYNC_STAGES-1];
   assign half    = baud_div >> 1;
   assign at_s0   = (cnt == half - DIV_W'(1));
   assign at_s1   = (cnt == half);
   assign at_vote = (cnt == half + DIV_W'(1));
   assign at_end  = (cnt == baud_div);
   assign vote    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

   // NOTE: every clocked block uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         smp      <= 2'b11;
         bit_idx  <= '0;
         shreg    <= '0;
         cfg_bits <= 2'b11;
         cfg_pen  <= 1'b0;
         cfg_podd <= 1'b0;
         cfg_stop2 <= 1'b0;
         stop_idx <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         seen_one <= 1'b0;
         dlv      <= 1'b0;
         dlv_perr <= 1'b0;
         dlv_ferr <= 1'b0;
         dlv_brk  <= 1'b0;
      end else begin
         dlv <= 1'b0;
         if (at_s0) smp[0] <= rx_s;
         if (at_s1) smp[1] <= rx_s;
         if (!uart_en) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            if (state != S_IDLE) cnt <= at_end ? '0 : cnt + DIV_W'(1);
            case (state)
               S_IDLE: if (rx_s_prev && !rx_s) begin
                  state     <= S_START;
                  cnt       <= '0;
                  cfg_bits  <= data_bits;
                  cfg_pen   <= parity_en;
                  cfg_podd  <= parity_odd;
                  cfg_stop2 <= stop2;
                  shreg     <= '0;
                  bit_idx   <= '0;
                  stop_idx  <= 1'b0;
                  perr      <= 1'b0;
                  ferr      <= 1'b0;
                  seen_one  <= 1'b0;
               end
               S_START: begin
                  if (at_vote && vote) begin
                     state <= S_IDLE;
                     cnt   <= '0;
                  end else if (at_end) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end
               end
               S_DATA: begin
                  if (at_vote) begin
                     shreg[bit_idx] <= vote;
                     seen_one       <= seen_one | vote;
                  end
                  if (at_end) begin
                     if (bit_idx == {1'b1, cfg_bits}) state <= cfg_pen ? S_PARITY : S_STOP;
                     else bit_idx <= bit_idx + 3'd1;
                  end
               end
               S_PARITY: begin
                  if (at_vote) begin
                     perr     <= (vote != ((^shreg) ^ cfg_podd));
                     seen_one <= seen_one | vote;
                  end
                  if (at_end) state <= S_STOP;
               end
               S_STOP: begin
                  // Early return at the last stop vote lets back-to-back frames resync.
                  if (cfg_stop2 && !stop_idx) begin
                     if (at_vote) begin
                        ferr     <= ferr | ~vote;
                        seen_one <= seen_one | vote;
                     end
                     if (at_end) stop_idx <= 1'b1;
                  end else if (at_vote) begin
                     dlv      <= 1'b1;
                     dlv_perr <= perr;
                     dlv_ferr <= ferr | ~vote;
                     dlv_brk  <= ~seen_one & ~vote;
                     state    <= S_IDLE;
                     cnt      <= '0;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign ovr_set = dlv && rx.rx_valid && !rx.rx_ready;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         rx.rx_valid   <= 1'b0;
         rx.rx_data    <= '0;
         rx.parity_err <= 1'b0;
         rx.frame_err  <= 1'b0;
         rx.break_det  <= 1'b0;
         rx.overrun    <= 1'b0;
      end else begin
         if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
         if (dlv && (!rx.rx_valid || rx.rx_ready)) begin
            rx.rx_valid   <= 1'b1;
            rx.rx_data    <= shreg;
            rx.parity_err <= dlv_perr;
            rx.frame_err  <= dlv_ferr;
            rx.break_det  <= dlv_brk;
         end
         if (ovr_set) rx.overrun <= 1'b1;
         else if (rx.ovr_clr) rx.overrun <= 1'b0;
      end
   end
endmodule
